// File: rtl/solver_pkg.sv
// Shared definitions for the solver arbiter: state encoding, default sizing
// and the result value returned on a timed-out job.
package solver_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 50_000_000;
    localparam int TO_W_DEF           = 26;

    localparam int TIMEOUT_RESULT = 0;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_RUN     = RUN,
        S_RELEASE = RELEASE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant; on a tie the requester that
// did not win last time (i_rr_ptr holds the last winner) is chosen.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_rr_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_ptr ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/solver_arbiter.sv
// Shares one solver core between two requesters: round-robin grant, four-phase
// start/done handshake, per-phase timeout and result return to the job owner.
module solver_arbiter
    import solver_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_W           = TO_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_x,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_result,
    output logic              req0_timeout,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_x,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_result,
    output logic              req1_timeout,
    output logic [DATA_W-1:0] sol_x,
    output logic              sol_start,
    input  logic [DATA_W-1:0] sol_result,
    input  logic              sol_done,
    output logic              busy,
    output logic              owner,
    output logic [7:0]        fault_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [DATA_W-1:0] r_sol_x;
    logic              r_done0;
    logic              r_done1;
    logic              r_to0;
    logic              r_to1;
    logic [DATA_W-1:0] r_res0;
    logic [DATA_W-1:0] r_res1;
    logic [7:0]        r_fault_cnt;

    logic              w_idle;
    logic [1:0]        w_grant;
    logic              w_expired;
    logic              w_job_ok;
    logic              w_job_to;
    logic              w_rel_to;
    logic [DATA_W-1:0] w_job_res;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Grant is qualified by reset so no ready pulse escapes while held in reset.
    assign w_idle    = (r_state == S_IDLE) && reset_n;
    assign w_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    rr_arb2 u_rr_arb2 (
        .i_valid  ({req1_valid & w_idle, req0_valid & w_idle}),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_job_ok    = 1'b0;
        w_job_to    = 1'b0;
        w_rel_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_grant) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A done arriving in the expiry cycle still counts as success.
                if (sol_done) begin
                    w_state_nxt = S_RELEASE;
                    w_job_ok    = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt = S_RELEASE;
                    w_job_to    = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!sol_done) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_rel_to    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_job_res = w_job_ok ? sol_result : DATA_W'(TIMEOUT_RESULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_rr_ptr    <= 1'b1;
            r_owner     <= 1'b0;
            r_sol_x     <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_to0       <= 1'b0;
            r_to1       <= 1'b0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_fault_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_to_cnt <= '0;
            else                                                 r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_grant[0]) begin
                r_sol_x  <= req0_x;
                r_owner  <= 1'b0;
                r_rr_ptr <= 1'b0;
            end else if (w_grant[1]) begin
                r_sol_x  <= req1_x;
                r_owner  <= 1'b1;
                r_rr_ptr <= 1'b1;
            end

            // Only the owner's result registers move; the other side holds.
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_job_ok || w_job_to) begin
                if (!r_owner) begin
                    r_done0 <= 1'b1;
                    r_res0  <= w_job_res;
                    r_to0   <= w_job_to;
                end else begin
                    r_done1 <= 1'b1;
                    r_res1  <= w_job_res;
                    r_to1   <= w_job_to;
                end
            end

            if (w_job_to || w_rel_to) r_fault_cnt <= sat_inc8(r_fault_cnt);
        end
    end

    assign req0_ready   = w_grant[0];
    assign req1_ready   = w_grant[1];
    assign req0_done    = r_done0;
    assign req1_done    = r_done1;
    assign req0_result  = r_res0;
    assign req1_result  = r_res1;
    assign req0_timeout = r_to0;
    assign req1_timeout = r_to1;
    assign sol_x        = r_sol_x;
    assign sol_start    = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign owner        = r_owner;
    assign fault_cnt    = r_fault_cnt;

endmodule

// File: tb/tb_solver_arbiter.sv
// Scoreboard bench for solver_arbiter with a small solver model whose result
// is x << 4 and whose done latency / stuck behaviour is set per job.
module tb_solver_arbiter;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic [31:0] req0_x = '0;
    logic [31:0] req1_x = '0;
    logic        req0_ready, req0_done, req0_timeout;
    logic        req1_ready, req1_done, req1_timeout;
    logic [31:0] req0_result, req1_result;
    logic [31:0] sol_x, sol_result;
    logic        sol_start, sol_done, busy, owner;
    logic [7:0]  fault_cnt;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    int   m_lat = 0;
    int   m_stuck = 0;
    int   scnt = 0;
    int   hold = 0;
    logic m_done = 1'b0;

    typedef struct {
        int          req;
        logic [31:0] res;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [32:0] prev0 = '0;
    logic [32:0] prev1 = '0;

    solver_arbiter #(.DATA_W(32), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_x       (req0_x),
        .req0_ready   (req0_ready),
        .req0_done    (req0_done),
        .req0_result  (req0_result),
        .req0_timeout (req0_timeout),
        .req1_valid   (req1_valid),
        .req1_x       (req1_x),
        .req1_ready   (req1_ready),
        .req1_done    (req1_done),
        .req1_result  (req1_result),
        .req1_timeout (req1_timeout),
        .sol_x        (sol_x),
        .sol_start    (sol_start),
        .sol_result   (sol_result),
        .sol_done     (sol_done),
        .busy         (busy),
        .owner        (owner),
        .fault_cnt    (fault_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Solver model: done rises in the m_lat-th cycle of start (never if 0),
    // then stays high m_stuck extra cycles after start falls.
    assign sol_result = sol_x << 4;
    assign sol_done   = m_done;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt   <= 0;
            hold   <= 0;
            m_done <= 1'b0;
        end else if (sol_start) begin
            scnt <= scnt + 1;
            if (scnt + 1 == m_lat - 1) m_done <= 1'b1;
        end else begin
            scnt <= 0;
            if (m_done) begin
                if (hold < m_stuck) hold <= hold + 1;
                else begin
                    m_done <= 1'b0;
                    hold   <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [31:0] res, input logic to, input int c);
        exp_t e;
        e.req = r;
        e.res = res;
        e.to  = to;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every done pulse; also checks that result
    // and timeout of each requester hold steady when no done pulse is shown.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req0_done && req1_done) begin
                n_checks++;
                n_err++;
                $display("FAIL dual_done: both done at cycle %0d, expected at most one", cyc);
            end else if (req0_done || req1_done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL extra_done: done from req%0d at cycle %0d, expected none", req1_done, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_req", 64'(req1_done), 64'(mon_e.req));
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("done_result", 64'(req1_done ? req1_result : req0_result), 64'(mon_e.res));
                    chk("done_timeout", 64'(req1_done ? req1_timeout : req0_timeout), 64'(mon_e.to));
                end
            end
            if (!req0_done) chk("hold0", 64'({req0_timeout, req0_result}), 64'(prev0));
            if (!req1_done) chk("hold1", 64'({req1_timeout, req1_result}), 64'(prev1));
        end
        prev0 = {req0_timeout, req0_result};
        prev1 = {req1_timeout, req1_result};
    end

    // Issues one job on an idle arbiter; returns the grant cycle.
    task automatic issue(input int n, input logic [31:0] x, input int lat,
                         input bit do_push, input bit to, output int t);
        @(posedge clk);
        #1;
        m_lat = lat;
        if (n == 0) begin req0_valid = 1'b1; req0_x = x; end
        else        begin req1_valid = 1'b1; req1_x = x; end
        @(negedge clk);
        t = cyc;
        chk("grant_ready", 64'(n == 0 ? req0_ready : req1_ready), 64'(1));
        if (do_push) push(n, to ? 32'h0 : (x << 4), to, to ? t + 1 + TO : t + 1 + lat);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("start_t1", 64'(sol_start), 64'(1));
        chk("sol_x", 64'(sol_x), 64'(x));
    endtask

    task automatic wait_busy_low(output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL busy_bound: busy still high after 200 cycles, expected low");
        end
    endtask

    task automatic wait_quiet();
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !sol_done) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL quiet_bound: arbiter/solver not quiet after 200 cycles");
        end
    endtask

    task automatic wait_any_ready(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_bound: no grant within 60 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        int g;

        @(negedge clk);
        chk("rst_req0_ready", 64'(req0_ready), 64'(0));
        chk("rst_req0_done", 64'(req0_done), 64'(0));
        chk("rst_req0_result", 64'(req0_result), 64'(0));
        chk("rst_req0_timeout", 64'(req0_timeout), 64'(0));
        chk("rst_req1_ready", 64'(req1_ready), 64'(0));
        chk("rst_req1_done", 64'(req1_done), 64'(0));
        chk("rst_req1_result", 64'(req1_result), 64'(0));
        chk("rst_req1_timeout", 64'(req1_timeout), 64'(0));
        chk("rst_sol_x", 64'(sol_x), 64'(0));
        chk("rst_sol_start", 64'(sol_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_fault_cnt", 64'(fault_cnt), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single job: done at t+6 with 0x100, idle at t+8.
        issue(0, 32'h10, 5, 1'b1, 1'b0, t);
        wait_busy_low(c);
        chk("single_idle_cycle", 64'(c), 64'(t + 8));
        chk("single_owner", 64'(owner), 64'(0));
        wait_quiet();

        // Contention after reset: req0 wins, req1 granted at t+6.
        do_reset();
        m_lat = 3;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_x = 32'd1;
        req1_valid = 1'b1; req1_x = 32'd2;
        @(negedge clk);
        t = cyc;
        chk("tie_ready0", 64'(req0_ready), 64'(1));
        chk("tie_ready1", 64'(req1_ready), 64'(0));
        push(0, 32'h10, 1'b0, t + 4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_any_ready(c);
        chk("tie_loser_ready", 64'(req1_ready), 64'(1));
        chk("tie_loser_cycle", 64'(c), 64'(t + 6));
        push(1, 32'h20, 1'b0, c + 4);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_quiet();

        // Both held: grants alternate 0,1,0,1.
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_x = 32'd3;
        req1_valid = 1'b1; req1_x = 32'd4;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(g);
            chk("alt_grant", 64'(req1_ready), 64'(k % 2));
            push(req1_ready ? 1 : 0, req1_ready ? 32'h40 : 32'h30, 1'b0, g + 4);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_quiet();

        // Timeout: done at t+21 (20 cycles after start rose), idle at t+22.
        issue(1, 32'd9, 0, 1'b1, 1'b1, t);
        wait_busy_low(c);
        chk("to_idle_cycle", 64'(c), 64'(t + 22));
        chk("to_fault_cnt", 64'(fault_cnt), 64'(1));
        chk("to_owner", 64'(owner), 64'(1));
        wait_quiet();

        // Stuck done: release phase expires, idle at t+24, one more fault.
        m_stuck = 30;
        issue(0, 32'd5, 3, 1'b1, 1'b0, t);
        wait_busy_low(c);
        chk("stuck_idle_cycle", 64'(c), 64'(t + 24));
        chk("stuck_fault_cnt", 64'(fault_cnt), 64'(2));
        wait_quiet();
        m_stuck = 0;

        // Done arrives in the expiry cycle: success wins, fault count unchanged.
        issue(1, 32'd6, TO, 1'b1, 1'b0, t);
        wait_busy_low(c);
        chk("race_fault_cnt", 64'(fault_cnt), 64'(2));
        wait_quiet();

        // Reset mid-job: outputs drop asynchronously, no done for that job.
        issue(1, 32'd8, 0, 1'b0, 1'b0, t);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_sol_start", 64'(sol_start), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_owner", 64'(owner), 64'(0));
        chk("midrst_fault_cnt", 64'(fault_cnt), 64'(0));
        chk("midrst_req1_done", 64'(req1_done), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(0, 32'd7, 3, 1'b1, 1'b0, t);
        wait_quiet();

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
